// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_adder_ctrl                                                          |
// | Bit-serial sequencer for an external 1-bit full-adder cell, LSB first.     |
// | Optional: SERIAL_ADDER_SUB_EN adds a 'sub' input for two's-complement a-b. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    always_comb begin
        b_load     = b;
        carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        // a - b = a + ~b + 1
        if (sub) begin
            b_load     = ~b;
            carry_load = 1'b1;
        end
`endif
    end

    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);
    assign fa_a   = busy & op_a[0];
    assign fa_b   = busy & op_b[0];
    assign fa_cin = busy & carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b_load;
                        carry <= carry_load;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    carry <= fa_cout;
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    // idx parks on the last bit rather than wrapping
                    if (idx == LAST_IDX) begin
                        cout  <= fa_cout;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// Testbench for serial_adder_ctrl: arithmetic reference model plus directed literal checks.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub   = 1'b0;
`endif
    logic             fa_a, fa_b, fa_cin, fa_s, fa_cout;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // The shared full-adder cell
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub     (sub),
`endif
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_s    (fa_s),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ph 0 = idle, 1..WIDTH = processing bit ph-1, WIDTH+1 = done cycle
    int               ph;
    logic [WIDTH-1:0] m_a, m_b, m_sum;
    logic             m_cin, m_cout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 0; m_a <= '0; m_b <= '0; m_cin <= 1'b0; m_sum <= '0; m_cout <= 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                ph     <= 1;
                m_a    <= a;
                m_b    <= b;
                m_cin  <= cin;
`ifdef SERIAL_ADDER_SUB_EN
                if (sub) begin
                    m_b   <= ~b;
                    m_cin <= 1'b1;
                end
`endif
                m_sum  <= '0;
                m_cout <= 1'b0;
            end
        end else if (ph == WIDTH) begin
            ph <= WIDTH + 1;
            {m_cout, m_sum} <= (WIDTH+1)'(m_a + m_b + m_cin);
        end else if (ph == WIDTH + 1) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    logic [63:0] full, mask;
    int          j;
    bit          run;
    always @(negedge clk) begin
        if (cmp_en) begin
            full = 64'(m_a) + 64'(m_b) + 64'(m_cin);
            run  = (ph >= 1) && (ph <= WIDTH);
            j    = ph - 1;
            chk("busy", 64'(busy), 64'(run));
            chk("done", 64'(done), 64'(ph == WIDTH + 1));
            if (run) begin
                mask = (64'd1 << j) - 64'd1;
                chk("fa_a",   64'(fa_a),   64'((m_a >> j) & 1));
                chk("fa_b",   64'(fa_b),   64'((m_b >> j) & 1));
                chk("fa_cin", 64'(fa_cin), ((64'(m_a) & mask) + (64'(m_b) & mask) + 64'(m_cin)) >> j);
                chk("sum_partial", 64'(sum), ((full & mask) << (WIDTH - j)) & 64'hFF);
                chk("cout_run", 64'(cout), 64'd0);
            end else begin
                chk("fa_idle", {61'd0, fa_a, fa_b, fa_cin}, 64'd0);
                chk("sum_hold",  64'(sum),  64'(m_sum));
                chk("cout_hold", 64'(cout), 64'(m_cout));
            end
        end
    end

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          output logic [7:0] s, output logic co, output int bc,
                          output int lat, output int nd,
                          output logic [7:0] cs, output logic [7:0] as);
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        s = '0; co = 1'b0; bc = 0; lat = 0; nd = 0; cs = '0; as = '0;
        for (int i = 0; i < 40 && nd == 0; i++) begin
            @(negedge clk);
            lat++;
            if (i == 0) begin
                start = 1'b0;
                a = ~av; b = ~bv; cin = ~cv;
            end
            if (busy) begin
                if (bc < 8) begin
                    cs[bc] = fa_cin;
                    as[bc] = fa_a;
                end
                bc++;
            end
            if (done) begin
                nd++; s = sum; co = cout;
            end
        end
        if (nd == 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] s, cs, as;
        logic       co;
        int         bc, lat, nd;

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_fa",   {61'd0, fa_a, fa_b, fa_cin}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; cmp_en = 1'b1;

        run_op(8'h00, 8'h00, 1'b0, s, co, bc, lat, nd, cs, as);
        chk("zero_sum", 64'(s), 64'h00);
        chk("zero_cout", 64'(co), 64'd0);
        chk("zero_busy_cycles", 64'(bc), 64'd8);
        chk("zero_latency", 64'(lat), 64'd9);
        chk("zero_done_count", 64'(nd), 64'd1);

        run_op(8'hFF, 8'h01, 1'b0, s, co, bc, lat, nd, cs, as);
        chk("ff01_sum", 64'(s), 64'h00);
        chk("ff01_cout", 64'(co), 64'd1);
        chk("ff01_fa_cin_seq", 64'(cs), 64'hFE);

        run_op(8'hA5, 8'h5A, 1'b1, s, co, bc, lat, nd, cs, as);
        chk("a55a_sum", 64'(s), 64'h00);
        chk("a55a_cout", 64'(co), 64'd1);
        chk("a55a_fa_a_seq", 64'(as), 64'hA5);

        // start during RUN is ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); a = 8'hFF; b = 8'hFF; start = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                nd++;
                chk("ign_sum", 64'(sum), 64'h46);
                chk("ign_cout", 64'(cout), 64'd0);
            end
        end
        chk("ign_done_count", 64'(nd), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ign_sum_hold", 64'(sum), 64'h46);
        end

        // asynchronous reset mid-RUN
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum",  64'(sum),  64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        chk("abort_fa",   {61'd0, fa_a, fa_b, fa_cin}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        run_op(8'h03, 8'h04, 1'b0, s, co, bc, lat, nd, cs, as);
        chk("post_rst_sum", 64'(s), 64'h07);
        chk("post_rst_cout", 64'(co), 64'd0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op(8'h05, 8'h07, 1'b0, s, co, bc, lat, nd, cs, as);
        chk("sub57_sum", 64'(s), 64'hFE);
        chk("sub57_cout", 64'(co), 64'd0);
        run_op(8'h07, 8'h05, 1'b0, s, co, bc, lat, nd, cs, as);
        chk("sub75_sum", 64'(s), 64'h02);
        chk("sub75_cout", 64'(co), 64'd1);
        sub = 1'b0;
`endif

        // random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a     = 8'($urandom);
            b     = 8'($urandom);
            cin   = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub   = 1'($urandom);
`endif
        end
        // start held high: back-to-back operations
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b1;
            a     = 8'($urandom);
            b     = 8'($urandom);
            cin   = 1'($urandom);
        end
        @(negedge clk); start = 1'b0;
        repeat (WIDTH + 4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
